frame_buf_mgr: RTL and testbench
================================

// Module: frame_buf_mgr
// PURPOSE
//  Parametrised N-buffer frame-buffer manager in the c3_clk0 (DDR user) domain. Hands the camera writer and
//  NUM_RD readers (VGA, USB) the DDR base address of a frame each. A reader never sees a frame the writer is
//  filling, and the writer never overwrites a frame a reader holds.
//  Successor to the fixed 2-bit frame_switch ping-pong: generalised buffer and reader count, drop accounting,
//  and per-reader new-frame strobes.
// PARAMETERS
//  NUM_BUFS     3            number of frame buffers in DDR, 2..8
//  NUM_RD       2            number of reader ports, 1..4
//  ADDR_W       30           DDR byte-address width
//  BASE_ADDR    30'h0        byte address of buffer 0
//  FRAME_STRIDE 30'h10_0000  byte distance between consecutive buffers
//  DROP_W       16           drop-counter width
// PORTS
//  c3_clk0       in   1               DDR user clock; all inputs are synchronous to it (CDC done upstream)
//  c3_rst0       in   1               asynchronous, active-high reset
//  wr_sof        in   1               1-cycle pulse: writer starts a frame
//  wr_eof        in   1               1-cycle pulse: writer finished the frame
//  wr_busy       out  1               writer owns a buffer
//  wr_buf        out  IDX_W           index of the writer buffer; IDX_W=clog2(NUM_BUFS), min 1
//  wr_base_addr  out  ADDR_W          DDR base address of the writer buffer
//  rd_sof        in   NUM_RD          per-reader 1-cycle pulse: reader starts a frame
//  rd_valid      out  NUM_RD          reader r holds a completed frame
//  rd_base_addr  out  NUM_RD*ADDR_W   reader r base address, reader 0 in the LSBs
//  rd_new_frame  out  NUM_RD          1-cycle pulse: a newer frame is ready
//  drop_cnt      out  DROP_W          frames lost to no-free-buffer or abort; saturating
// BEHAVIOUR
//  Per-buffer state:
//   - WRITING flag, reader mask [NUM_RD], LATEST flag.
//   - A buffer is FREE when it is not WRITING, its mask is 0 and it is not LATEST.
//   - At most one buffer is WRITING and at most one is LATEST.
//  Reset (async): all buffers FREE, no LATEST, wr_busy=0, wr_buf=0, wr_base_addr=BASE_ADDR, rd_valid=0,
//   rd_base_addr=BASE_ADDR in every slot, rd_new_frame=0, drop_cnt=0. Reset mid-frame discards all ownership.
//  All outputs are registered and update 1 cycle after the causing pulse. No combinational in->out path.
//  Same-cycle event order: wr_eof, then rd_sof (all readers), then wr_sof.
//  wr_eof:
//   - Ignored when wr_busy=0.
//   - Otherwise the WRITING buffer becomes LATEST and wr_busy goes 0.
//   - The old LATEST loses the flag; it becomes FREE if its mask is 0.
//   - rd_new_frame = all ones for one cycle.
//  rd_sof[r]:
//   - If a LATEST exists: set bit r on LATEST, clear bit r on the previously held buffer; rd_base_addr[r]
//     points at LATEST and rd_valid[r]=1.
//   - If LATEST is already held by r: no change.
//   - If no LATEST exists: reader keeps its current buffer, or rd_valid[r] stays 0 if it holds none.
//  wr_sof:
//   - wr_busy=1: abort. Keep the same buffer and base, drop_cnt+1.
//   - Else pick the lowest-index FREE buffer: WRITING=1, wr_busy=1, wr_buf and wr_base_addr updated.
//   - No FREE buffer: wr_busy stays 0, wr_buf and wr_base_addr hold, drop_cnt+1, and the writer must ignore
//     the frame.
//  Address: base = BASE_ADDR + idx*FRAME_STRIDE, truncated mod 2^ADDR_W. No multiplier; use a constant
//   table or an adder chain.
//  drop_cnt saturates at 2^DROP_W-1.
//  NUM_BUFS >= NUM_RD+2 guarantees a FREE buffer at every wr_sof; smaller configurations must still obey the
//   drop rule.
// STRUCTURE
//  fbm_defs.vh: IDX_W clog2 function, address-table generation macro, event-order constants.
//  Sub-module fbm_free_pick: combinational lowest-index priority encoder over the FREE vector
//   -> {found, idx}.
//  The rest is one always block per state group: buffer flags, writer regs, reader regs, counter.
// TESTING
//  1 Defaults, reset released:
//    - wr_sof -> wr_busy=1, wr_buf=0, wr_base=0.
//    - wr_eof -> rd_new_frame=2'b11 for 1 cycle.
//    - rd_sof=2'b01 -> rd_valid=01, rd_base[0]=0.
//  2 NUM_RD=1, reader holds buf0; run 4 writer frames -> wr_buf sequence 1,2,1,2. Never 0 while held.
//  3 Full: reader0 holds buf0, reader1 holds buf1, buf2 completed and LATEST; then wr_sof -> wr_busy=0,
//    drop_cnt=1, wr_base unchanged.
//  4 wr_eof on buf1 and rd_sof[0] in the same cycle -> rd_base[0]=30'h10_0000 next cycle.
//  5 wr_sof, wr_sof without eof -> wr_buf unchanged, drop_cnt=1.
//  6 Set drop_cnt to DROP_W max -> stays there.
//  7 Assert c3_rst0 mid-write (wr_busy=1) -> every output is at its reset value in the same cycle, before the
//    next clock edge.

Source files
------------

// File: rtl/frame_buf_mgr_pkg.sv
// Shared helpers for the frame-buffer manager: index-width calculation.
package frame_buf_mgr_pkg;

  // Width of a buffer index: ceil(log2(n)), never less than one bit.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/frame_buf_mgr_free_pick.sv
// Lowest-index priority encoder over the FREE vector -> {found, idx}.
module frame_buf_mgr_free_pick
  import frame_buf_mgr_pkg::*;
#(
  parameter int NUM_BUFS = 3,
  parameter int IDX_W    = idx_width(NUM_BUFS)
) (
  input  logic [NUM_BUFS-1:0] free,
  output logic                found,
  output logic [IDX_W-1:0]    idx
);

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    found = |free;
    idx   = '0;
    for (int b = NUM_BUFS - 1; b >= 0; b--) begin
      if (free[b]) idx = IDX_W'(b);
    end
  end

endmodule

// File: rtl/frame_buf_mgr.sv
// N-buffer frame-buffer manager for one camera writer and NUM_RD readers.
// Pulse semantics: wr_sof, wr_eof and rd_sof[r] are single-cycle strobes with
// no back-pressure; they are acted on in the cycle they are high and every
// output reflects them one clock later. Within one cycle the events are
// applied in the order wr_eof, rd_sof (all readers), wr_sof.
module frame_buf_mgr
  import frame_buf_mgr_pkg::*;
#(
  parameter int                NUM_BUFS     = 3,
  parameter int                NUM_RD       = 2,
  parameter int                ADDR_W       = 30,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 30'h0,
  parameter logic [ADDR_W-1:0] FRAME_STRIDE = 30'h10_0000,
  parameter int                DROP_W       = 16,
  localparam int               IDX_W        = idx_width(NUM_BUFS)
) (
  input  logic                     c3_clk0,
  input  logic                     c3_rst0,
  input  logic                     wr_sof,
  input  logic                     wr_eof,
  output logic                     wr_busy,
  output logic [IDX_W-1:0]         wr_buf,
  output logic [ADDR_W-1:0]        wr_base_addr,
  input  logic [NUM_RD-1:0]        rd_sof,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic [NUM_RD*ADDR_W-1:0] rd_base_addr,
  output logic [NUM_RD-1:0]        rd_new_frame,
  output logic [DROP_W-1:0]        drop_cnt
);

  // Base address of buffer idx built with an adder chain (constant-folded).
  function automatic logic [ADDR_W-1:0] buf_addr(input int idx);
    logic [ADDR_W-1:0] a;
    a = BASE_ADDR;
    for (int i = 0; i < idx; i++) a = a + FRAME_STRIDE;
    return a;
  endfunction

  logic [ADDR_W-1:0] addr_tab [NUM_BUFS];

  for (genvar b = 0; b < NUM_BUFS; b++) begin : g_addr
    assign addr_tab[b] = buf_addr(b);
  end

  // Registered state.
  logic [NUM_BUFS-1:0] writing_q;
  logic [NUM_BUFS-1:0] latest_q;
  logic [NUM_RD-1:0]   mask_q [NUM_BUFS];
  logic                wr_busy_q;
  logic [IDX_W-1:0]    wr_buf_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [NUM_RD-1:0]   rd_valid_q;
  logic [NUM_RD-1:0]   rd_new_q;
  logic [IDX_W-1:0]    rd_idx_q  [NUM_RD];
  logic [ADDR_W-1:0]   rd_addr_q [NUM_RD];
  logic [DROP_W-1:0]   drop_q;

  // State after wr_eof and rd_sof have been applied.
  logic [NUM_BUFS-1:0] writing_a;
  logic [NUM_BUFS-1:0] latest_a;
  logic [NUM_RD-1:0]   mask_a [NUM_BUFS];
  logic [NUM_BUFS-1:0] free_a;
  logic                busy_a;
  logic                lat_any;
  logic [IDX_W-1:0]    lat_idx;
  logic [ADDR_W-1:0]   lat_addr;
  logic [NUM_RD-1:0]   rd_valid_n;
  logic [NUM_RD-1:0]   rd_new_n;
  logic [IDX_W-1:0]    rd_idx_n  [NUM_RD];
  logic [ADDR_W-1:0]   rd_addr_n [NUM_RD];

  // State after wr_sof has been applied.
  logic [NUM_BUFS-1:0] writing_n;
  logic                busy_n;
  logic [IDX_W-1:0]    wr_buf_n;
  logic [ADDR_W-1:0]   wr_addr_n;
  logic                drop_inc;
  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx;
  logic [ADDR_W-1:0]   pick_addr;

  // Apply wr_eof, then every reader's rd_sof, and derive the FREE vector.
  always_comb begin
    writing_a  = writing_q;
    latest_a   = latest_q;
    mask_a     = mask_q;
    busy_a     = wr_busy_q;
    rd_valid_n = rd_valid_q;
    rd_new_n   = '0;
    rd_idx_n   = rd_idx_q;
    rd_addr_n  = rd_addr_q;
    lat_any    = 1'b0;
    lat_idx    = '0;
    lat_addr   = BASE_ADDR;
    free_a     = '0;

    // Completed frame becomes LATEST; the previous LATEST just loses the flag.
    if (wr_eof && wr_busy_q) begin
      latest_a  = writing_q;
      writing_a = '0;
      busy_a    = 1'b0;
      rd_new_n  = '1;
    end

    lat_any = |latest_a;
    for (int b = 0; b < NUM_BUFS; b++) begin
      if (latest_a[b]) begin
        lat_idx  = IDX_W'(b);
        lat_addr = addr_tab[b];
      end
    end

    // A reader moves to LATEST unless it already holds it.
    for (int r = 0; r < NUM_RD; r++) begin
      if (rd_sof[r] && lat_any && !(rd_valid_q[r] && (rd_idx_q[r] == lat_idx))) begin
        for (int b = 0; b < NUM_BUFS; b++) begin
          if (rd_valid_q[r] && (rd_idx_q[r] == IDX_W'(b))) mask_a[b][r] = 1'b0;
          if (lat_idx == IDX_W'(b)) mask_a[b][r] = 1'b1;
        end
        rd_valid_n[r] = 1'b1;
        rd_idx_n[r]   = lat_idx;
        rd_addr_n[r]  = lat_addr;
      end
    end

    for (int b = 0; b < NUM_BUFS; b++) begin
      free_a[b] = !writing_a[b] && (mask_a[b] == '0) && !latest_a[b];
    end
  end

  frame_buf_mgr_free_pick #(
    .NUM_BUFS (NUM_BUFS),
    .IDX_W    (IDX_W)
  ) u_free_pick (
    .free  (free_a),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Apply wr_sof: abort a running frame, claim a FREE buffer, or drop.
  always_comb begin
    writing_n = writing_a;
    busy_n    = busy_a;
    wr_buf_n  = wr_buf_q;
    wr_addr_n = wr_addr_q;
    drop_inc  = 1'b0;
    pick_addr = BASE_ADDR;

    for (int b = 0; b < NUM_BUFS; b++) begin
      if (pick_idx == IDX_W'(b)) pick_addr = addr_tab[b];
    end

    if (wr_sof) begin
      if (busy_a) begin
        drop_inc = 1'b1;
      end else if (pick_found) begin
        for (int b = 0; b < NUM_BUFS; b++) begin
          if (pick_idx == IDX_W'(b)) writing_n[b] = 1'b1;
        end
        busy_n    = 1'b1;
        wr_buf_n  = pick_idx;
        wr_addr_n = pick_addr;
      end else begin
        drop_inc = 1'b1;
      end
    end
  end

  // Per-buffer flags: WRITING, LATEST and reader masks.
  always_ff @(posedge c3_clk0 or posedge c3_rst0) begin
    if (c3_rst0) begin
      writing_q <= '0;
      latest_q  <= '0;
      mask_q    <= '{default: '0};
    end else begin
      writing_q <= writing_n;
      latest_q  <= latest_a;
      mask_q    <= mask_a;
    end
  end

  // Writer-facing registers.
  always_ff @(posedge c3_clk0 or posedge c3_rst0) begin
    if (c3_rst0) begin
      wr_busy_q <= 1'b0;
      wr_buf_q  <= '0;
      wr_addr_q <= BASE_ADDR;
    end else begin
      wr_busy_q <= busy_n;
      wr_buf_q  <= wr_buf_n;
      wr_addr_q <= wr_addr_n;
    end
  end

  // Reader-facing registers.
  always_ff @(posedge c3_clk0 or posedge c3_rst0) begin
    if (c3_rst0) begin
      rd_valid_q <= '0;
      rd_new_q   <= '0;
      rd_idx_q   <= '{default: '0};
      rd_addr_q  <= '{default: BASE_ADDR};
    end else begin
      rd_valid_q <= rd_valid_n;
      rd_new_q   <= rd_new_n;
      rd_idx_q   <= rd_idx_n;
      rd_addr_q  <= rd_addr_n;
    end
  end

  // Saturating count of frames lost to abort or no free buffer.
  always_ff @(posedge c3_clk0 or posedge c3_rst0) begin
    if (c3_rst0) begin
      drop_q <= '0;
    end else if (drop_inc && (drop_q != {DROP_W{1'b1}})) begin
      drop_q <= drop_q + DROP_W'(1);
    end
  end

  assign wr_busy      = wr_busy_q;
  assign wr_buf       = wr_buf_q;
  assign wr_base_addr = wr_addr_q;
  assign rd_valid     = rd_valid_q;
  assign rd_new_frame = rd_new_q;
  assign drop_cnt     = drop_q;

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd_out
    assign rd_base_addr[r*ADDR_W +: ADDR_W] = rd_addr_q[r];
  end

endmodule

// File: tb/tb_frame_buf_mgr.sv
// Bench for frame_buf_mgr: table of single-cycle vectors on the default
// configuration, plus hand sequences on a one-reader instance and a reset
// check mid-write.
module tb_frame_buf_mgr;

  localparam logic [29:0] A0 = 30'h000_0000;
  localparam logic [29:0] A1 = 30'h010_0000;
  localparam logic [29:0] A2 = 30'h020_0000;
  localparam int          NV = 20;

  typedef struct packed {
    logic        busy;
    logic [1:0]  buf_i;
    logic [29:0] base;
    logic [1:0]  rdv;
    logic [29:0] rb0;
    logic [29:0] rb1;
    logic [1:0]  nf;
    logic [15:0] drop;
  } outs_t;

  typedef struct packed {
    logic       wsof;
    logic       weof;
    logic [1:0] rsof;
    outs_t      exp;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main DUT (defaults) ----------------
  logic        wr_sof = 1'b0, wr_eof = 1'b0;
  logic [1:0]  rd_sof = 2'b00;
  logic        wr_busy;
  logic [1:0]  wr_buf;
  logic [29:0] wr_base_addr;
  logic [1:0]  rd_valid;
  logic [59:0] rd_base_addr;
  logic [1:0]  rd_new_frame;
  logic [15:0] drop_cnt;

  frame_buf_mgr dut (
    .c3_clk0      (clk),
    .c3_rst0      (rst),
    .wr_sof       (wr_sof),
    .wr_eof       (wr_eof),
    .wr_busy      (wr_busy),
    .wr_buf       (wr_buf),
    .wr_base_addr (wr_base_addr),
    .rd_sof       (rd_sof),
    .rd_valid     (rd_valid),
    .rd_base_addr (rd_base_addr),
    .rd_new_frame (rd_new_frame),
    .drop_cnt     (drop_cnt)
  );

  // ---------------- one-reader DUT, narrow drop counter ----------------
  logic        b_wr_sof = 1'b0, b_wr_eof = 1'b0;
  logic [0:0]  b_rd_sof = 1'b0;
  logic        b_wr_busy;
  logic [1:0]  b_wr_buf;
  logic [29:0] b_wr_base;
  logic [0:0]  b_rd_valid;
  logic [29:0] b_rd_base;
  logic [0:0]  b_rd_new;
  logic [2:0]  b_drop;

  frame_buf_mgr #(.NUM_BUFS(3), .NUM_RD(1), .DROP_W(3)) dut_b (
    .c3_clk0      (clk),
    .c3_rst0      (rst),
    .wr_sof       (b_wr_sof),
    .wr_eof       (b_wr_eof),
    .wr_busy      (b_wr_busy),
    .wr_buf       (b_wr_buf),
    .wr_base_addr (b_wr_base),
    .rd_sof       (b_rd_sof),
    .rd_valid     (b_rd_valid),
    .rd_base_addr (b_rd_base),
    .rd_new_frame (b_rd_new),
    .drop_cnt     (b_drop)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic wsof, input logic weof, input logic [1:0] rsof,
                              input logic busy, input logic [1:0] bi, input logic [29:0] base,
                              input logic [1:0] rdv, input logic [29:0] rb0, input logic [29:0] rb1,
                              input logic [1:0] nf, input logic [15:0] drop);
    vec_t v;
    v.wsof = wsof; v.weof = weof; v.rsof = rsof;
    v.exp.busy = busy; v.exp.buf_i = bi; v.exp.base = base; v.exp.rdv = rdv;
    v.exp.rb0 = rb0; v.exp.rb1 = rb1; v.exp.nf = nf; v.exp.drop = drop;
    return v;
  endfunction

  // One cycle on the one-reader instance: drive at negedge, sample #1 after posedge.
  task automatic b_step(input logic sof, input logic eof, input logic rs);
    @(negedge clk);
    b_wr_sof = sof; b_wr_eof = eof; b_rd_sof = rs;
    @(posedge clk);
    #1;
    b_wr_sof = 1'b0; b_wr_eof = 1'b0; b_rd_sof = 1'b0;
  endtask

  vec_t  vecs [NV];
  outs_t got;

  logic [1:0] seq_exp [4];

  initial begin
    // ---- vector table (state carries from one row to the next) ----
    //               sof eof rsof busy buf base rdv  rb0 rb1 nf    drop
    vecs[0]  = mk(1, 0, 2'b00, 1, 0, A0, 2'b00, A0, A0, 2'b00, 0); // first frame -> buf0
    vecs[1]  = mk(0, 0, 2'b00, 1, 0, A0, 2'b00, A0, A0, 2'b00, 0);
    vecs[2]  = mk(0, 1, 2'b00, 0, 0, A0, 2'b00, A0, A0, 2'b11, 0); // new-frame strobe
    vecs[3]  = mk(0, 0, 2'b00, 0, 0, A0, 2'b00, A0, A0, 2'b00, 0); // strobe is one cycle
    vecs[4]  = mk(0, 0, 2'b01, 0, 0, A0, 2'b01, A0, A0, 2'b00, 0); // reader0 takes buf0
    vecs[5]  = mk(1, 0, 2'b00, 1, 1, A1, 2'b01, A0, A0, 2'b00, 0); // buf0 held -> buf1
    vecs[6]  = mk(0, 1, 2'b00, 0, 1, A1, 2'b01, A0, A0, 2'b11, 0);
    vecs[7]  = mk(0, 0, 2'b10, 0, 1, A1, 2'b11, A0, A1, 2'b00, 0); // reader1 takes buf1
    vecs[8]  = mk(1, 0, 2'b00, 1, 2, A2, 2'b11, A0, A1, 2'b00, 0);
    vecs[9]  = mk(0, 1, 2'b00, 0, 2, A2, 2'b11, A0, A1, 2'b11, 0); // buf2 LATEST
    vecs[10] = mk(1, 0, 2'b00, 0, 2, A2, 2'b11, A0, A1, 2'b00, 1); // no free: drop
    vecs[11] = mk(0, 0, 2'b01, 0, 2, A2, 2'b11, A2, A1, 2'b00, 1); // reader0 -> buf2, buf0 free
    vecs[12] = mk(1, 0, 2'b00, 1, 0, A0, 2'b11, A2, A1, 2'b00, 1);
    vecs[13] = mk(1, 0, 2'b00, 1, 0, A0, 2'b11, A2, A1, 2'b00, 2); // abort keeps buffer
    vecs[14] = mk(1, 1, 2'b10, 1, 1, A1, 2'b11, A2, A0, 2'b11, 2); // eof, rd1, sof same cycle
    vecs[15] = mk(0, 0, 2'b01, 1, 1, A1, 2'b11, A0, A0, 2'b00, 2);
    vecs[16] = mk(0, 1, 2'b01, 0, 1, A1, 2'b11, A1, A0, 2'b11, 2); // eof on buf1 + rd_sof[0]
    vecs[17] = mk(0, 0, 2'b01, 0, 1, A1, 2'b11, A1, A0, 2'b00, 2); // already on LATEST
    vecs[18] = mk(0, 0, 2'b11, 0, 1, A1, 2'b11, A1, A1, 2'b00, 2);
    vecs[19] = mk(1, 0, 2'b00, 1, 0, A0, 2'b11, A1, A1, 2'b00, 2); // buf0 free again

    seq_exp[0] = 2'd1; seq_exp[1] = 2'd2; seq_exp[2] = 2'd1; seq_exp[3] = 2'd2;

    // ---- reset values while reset is held ----
    #12;
    chk("rst_busy", {63'd0, wr_busy}, 64'd0);
    chk("rst_rd_valid", {62'd0, rd_valid}, 64'd0);
    chk("rst_rd_base", {4'd0, rd_base_addr}, {4'd0, A0, A0});
    chk("rst_drop", {48'd0, drop_cnt}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // ---- table-driven vectors on the default instance ----
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      wr_sof = vecs[i].wsof;
      wr_eof = vecs[i].weof;
      rd_sof = vecs[i].rsof;
      @(posedge clk);
      #1;
      got.busy  = wr_busy;
      got.buf_i = wr_buf;
      got.base  = wr_base_addr;
      got.rdv   = rd_valid;
      got.rb0   = rd_base_addr[29:0];
      got.rb1   = rd_base_addr[59:30];
      got.nf    = rd_new_frame;
      got.drop  = drop_cnt;
      n_vec++;
      if (got !== vecs[i].exp) begin
        n_bad++;
        $display("FAIL vec%0d got busy=%b buf=%0d base=%h rdv=%b rb0=%h rb1=%h nf=%b drop=%0d exp busy=%b buf=%0d base=%h rdv=%b rb0=%h rb1=%h nf=%b drop=%0d",
                 i, got.busy, got.buf_i, got.base, got.rdv, got.rb0, got.rb1, got.nf, got.drop,
                 vecs[i].exp.busy, vecs[i].exp.buf_i, vecs[i].exp.base, vecs[i].exp.rdv,
                 vecs[i].exp.rb0, vecs[i].exp.rb1, vecs[i].exp.nf, vecs[i].exp.drop);
      end
    end
    @(negedge clk);
    wr_sof = 1'b0; wr_eof = 1'b0; rd_sof = 2'b00;

    // ---- one reader pins buf0; the writer must alternate 1,2,1,2 ----
    b_step(1'b1, 1'b0, 1'b0);
    chk("b_first_buf", {62'd0, b_wr_buf}, 64'd0);
    b_step(1'b0, 1'b1, 1'b0);
    b_step(1'b0, 1'b0, 1'b1);
    chk("b_rd_valid", {63'd0, b_rd_valid}, 64'd1);
    chk("b_rd_base", {34'd0, b_rd_base}, {34'd0, A0});
    for (int k = 0; k < 4; k++) begin
      b_step(1'b1, 1'b0, 1'b0);
      chk($sformatf("b_seq%0d_buf", k), {62'd0, b_wr_buf}, {62'd0, seq_exp[k]});
      chk($sformatf("b_seq%0d_base", k), {34'd0, b_wr_base},
          {34'd0, (seq_exp[k] == 2'd1) ? A1 : A2});
      b_step(1'b0, 1'b1, 1'b0);
      chk($sformatf("b_seq%0d_new", k), {63'd0, b_rd_new}, 64'd1);
    end
    chk("b_rd_still_buf0", {34'd0, b_rd_base}, {34'd0, A0});

    // ---- drop counter saturates at 2^3-1 ----
    b_step(1'b1, 1'b0, 1'b0);
    chk("b_sat_start_busy", {63'd0, b_wr_busy}, 64'd1);
    chk("b_sat_start_drop", {61'd0, b_drop}, 64'd0);
    for (int i = 1; i <= 9; i++) begin
      b_step(1'b1, 1'b0, 1'b0);
      chk($sformatf("b_sat_drop%0d", i), {61'd0, b_drop}, (i > 7) ? 64'd7 : 64'(i));
    end

    // ---- asynchronous reset mid-write ----
    @(negedge clk);
    wr_sof = 1'b1;
    @(posedge clk);
    #1;
    wr_sof = 1'b0;
    chk("pre_rst_busy", {63'd0, wr_busy}, 64'd1);
    chk("pre_rst_drop", {48'd0, drop_cnt}, 64'd3);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", {63'd0, wr_busy}, 64'd0);
    chk("arst_buf", {62'd0, wr_buf}, 64'd0);
    chk("arst_base", {34'd0, wr_base_addr}, {34'd0, A0});
    chk("arst_rd_valid", {62'd0, rd_valid}, 64'd0);
    chk("arst_rd_base", {4'd0, rd_base_addr}, {4'd0, A0, A0});
    chk("arst_new", {62'd0, rd_new_frame}, 64'd0);
    chk("arst_drop", {48'd0, drop_cnt}, 64'd0);
    chk("arst_b_drop", {61'd0, b_drop}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Ownership was discarded: buf0 is free for the next frame.
    @(negedge clk);
    rd_sof = 2'b11;
    @(posedge clk);
    #1;
    rd_sof = 2'b00;
    chk("post_rst_no_latest", {62'd0, rd_valid}, 64'd0);
    @(negedge clk);
    wr_sof = 1'b1;
    @(posedge clk);
    #1;
    wr_sof = 1'b0;
    chk("post_rst_buf", {62'd0, wr_buf}, 64'd0);
    chk("post_rst_busy", {63'd0, wr_busy}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
